// File: rtl/hazard_control_unit_pkg.sv
// rtl/hazard_control_unit_pkg.sv - shared pipeline hazard definitions: FSM states, control vectors, timeout default
package hazard_control_unit_pkg;

    localparam int MEM_TIMEOUT_DEFAULT = 255;
    localparam int WAIT_W              = 8;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MDU_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } hcu_state_e;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic flush_id;
        logic flush_ex;
        logic flush_mem;
        logic pc_write_en;
        logic pc_redirect;
    } hcu_ctrl_t;

    // Bit order: stall if/id/ex/mem, flush id/ex/mem, pc_write_en, pc_redirect
    localparam hcu_ctrl_t CTRL_NONE     = 9'b0000_000_1_0;
    localparam hcu_ctrl_t CTRL_MEM      = 9'b1111_000_0_0;
    localparam hcu_ctrl_t CTRL_MDU      = 9'b1110_001_0_0;
    localparam hcu_ctrl_t CTRL_BRANCH   = 9'b0000_110_1_1;
    localparam hcu_ctrl_t CTRL_LOAD_USE = 9'b1100_010_0_0;

    function automatic logic load_use_hazard(
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       rs1_used,
        input logic       rs2_used,
        input logic [4:0] rd,
        input logic       mem_read
    );
        return mem_read && (rd != 5'd0) &&
               ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// rtl/hazard_control_unit_if.sv - pipeline status in / stall-flush control out bundle
interface hazard_control_unit_if;

    logic [4:0]  RS1_ID;
    logic [4:0]  RS2_ID;
    logic        RS1_USED_ID;
    logic        RS2_USED_ID;
    logic [4:0]  RD_EX;
    logic        MEM_READ_EX;
    logic        BRANCH_TAKEN_EX;
    logic        MDU_START_EX;
    logic        MDU_DONE;
    logic        MEM_REQ_MEM;
    logic        DCACHE_READY;

    logic        STALL_IF;
    logic        STALL_ID;
    logic        STALL_EX;
    logic        STALL_MEM;
    logic        FLUSH_ID;
    logic        FLUSH_EX;
    logic        FLUSH_MEM;
    logic        PC_WRITE_EN;
    logic        PC_REDIRECT;
    logic        ERROR;
    logic [31:0] STALL_CYCLES;

    modport master (
        output RS1_ID, RS2_ID, RS1_USED_ID, RS2_USED_ID, RD_EX, MEM_READ_EX,
               BRANCH_TAKEN_EX, MDU_START_EX, MDU_DONE, MEM_REQ_MEM, DCACHE_READY,
        input  STALL_IF, STALL_ID, STALL_EX, STALL_MEM, FLUSH_ID, FLUSH_EX,
               FLUSH_MEM, PC_WRITE_EN, PC_REDIRECT, ERROR, STALL_CYCLES
    );

    modport slave (
        input  RS1_ID, RS2_ID, RS1_USED_ID, RS2_USED_ID, RD_EX, MEM_READ_EX,
               BRANCH_TAKEN_EX, MDU_START_EX, MDU_DONE, MEM_REQ_MEM, DCACHE_READY,
        output STALL_IF, STALL_ID, STALL_EX, STALL_MEM, FLUSH_ID, FLUSH_EX,
               FLUSH_MEM, PC_WRITE_EN, PC_REDIRECT, ERROR, STALL_CYCLES
    );

endinterface

// File: rtl/hazard_control_unit_wait_timer.sv
// rtl/hazard_control_unit_wait_timer.sv - memory-wait cycle counter with terminal-count flag
module hazard_control_unit_wait_timer
    import hazard_control_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic inc_i,
    output logic tc_o
);

    logic [WAIT_W-1:0] count_q;
    logic [WAIT_W-1:0] count_d;

    // Entering the wait state already counts as the first wait cycle
    always_comb begin
        count_d = count_q;
        if (start_i) begin
            count_d = WAIT_W'(1);
        end else if (inc_i) begin
            count_d = count_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == WAIT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline stall/flush/redirect controller with memory-wait timeout
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RST,
    hazard_control_unit_if.slave  hz
);

    hcu_state_e  state_q;
    hcu_state_e  state_d;
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;
    hcu_ctrl_t   ctrl;
    logic        error_flag;
    logic        run_rules;
    logic        tmr_start;
    logic        tmr_inc;
    logic        tmr_tc;
    logic        load_use;

    assign load_use = load_use_hazard(hz.RS1_ID, hz.RS2_ID, hz.RS1_USED_ID, hz.RS2_USED_ID,
                                      hz.RD_EX, hz.MEM_READ_EX);

    hazard_control_unit_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk_i   (CLK),
        .rst_i   (RST),
        .start_i (tmr_start),
        .inc_i   (tmr_inc),
        .tc_o    (tmr_tc)
    );

    always_comb begin
        state_d    = state_q;
        ctrl       = CTRL_NONE;
        error_flag = 1'b0;
        run_rules  = 1'b0;
        tmr_start  = 1'b0;
        tmr_inc    = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (hz.MEM_REQ_MEM && !hz.DCACHE_READY) begin
                    ctrl      = CTRL_MEM;
                    state_d   = ST_MEM_WAIT;
                    tmr_start = 1'b1;
                end else begin
                    run_rules = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (!hz.DCACHE_READY) begin
                    ctrl = CTRL_MEM;
                    if (tmr_tc) begin
                        state_d = ST_ERROR;
                    end else begin
                        tmr_inc = 1'b1;
                    end
                end else begin
                    // The held EX instruction gets its normal treatment on the exit cycle
                    state_d   = ST_RUN;
                    run_rules = 1'b1;
                end
            end
            ST_MDU_WAIT: begin
                if (!hz.MDU_DONE) begin
                    ctrl = CTRL_MDU;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_ERROR: begin
                ctrl       = CTRL_MEM;
                error_flag = 1'b1;
            end
        endcase

        if (run_rules) begin
            if (hz.MDU_START_EX && !hz.MDU_DONE) begin
                ctrl    = CTRL_MDU;
                state_d = ST_MDU_WAIT;
            end else if (hz.BRANCH_TAKEN_EX) begin
                ctrl = CTRL_BRANCH;
            end else if (load_use) begin
                ctrl = CTRL_LOAD_USE;
            end
        end

        if (RST) begin
            ctrl       = CTRL_NONE;
            error_flag = 1'b0;
            tmr_start  = 1'b0;
            tmr_inc    = 1'b0;
        end
    end

    assign stall_cycles_d = ctrl.stall_if ? stall_cycles_q + 32'd1 : stall_cycles_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= ST_RUN;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign hz.STALL_IF     = ctrl.stall_if;
    assign hz.STALL_ID     = ctrl.stall_id;
    assign hz.STALL_EX     = ctrl.stall_ex;
    assign hz.STALL_MEM    = ctrl.stall_mem;
    assign hz.FLUSH_ID     = ctrl.flush_id;
    assign hz.FLUSH_EX     = ctrl.flush_ex;
    assign hz.FLUSH_MEM    = ctrl.flush_mem;
    assign hz.PC_WRITE_EN  = ctrl.pc_write_en;
    assign hz.PC_REDIRECT  = ctrl.pc_redirect;
    assign hz.ERROR        = error_flag;
    assign hz.STALL_CYCLES = stall_cycles_q;

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: HAZARD_CONTROL_UNIT

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, range 1..255; max consecutive MEM_WAIT cycles before ERROR.
REQ-002 Clocking: one clock; reset is synchronous and active-high; ports named CLK and RST.
REQ-003 CLK  input  1  pipeline clock, rising edge.
REQ-004 RST  input  1  synchronous active-high reset.
REQ-005 RS1_ID, RS2_ID  input  5 each  source register addresses of instruction in ID.
REQ-006 RS1_USED_ID, RS2_USED_ID  input  1 each  matching source operand actually read.
REQ-007 RD_EX  input  5  destination register of instruction in EX.
REQ-008 MEM_READ_EX  input  1  instruction in EX is a load.
REQ-009 BRANCH_TAKEN_EX  input  1  branch/jump resolved taken in EX; redirect PC.
REQ-010 MDU_START_EX  input  1  multi-cycle mul/div in EX.
REQ-011 MDU_DONE  input  1  mul/div result valid this cycle.
REQ-012 MEM_REQ_MEM  input  1  load/store in MEM stage.
REQ-013 DCACHE_READY  input  1  data memory completes MEM access this cycle.
REQ-014 STALL_IF, STALL_ID, STALL_EX, STALL_MEM  output  1 each  hold that pipeline register.
REQ-015 FLUSH_ID, FLUSH_EX, FLUSH_MEM  output  1 each  load bubble into that pipeline register.
REQ-016 PC_WRITE_EN  output  1  PC may update.
REQ-017 PC_REDIRECT  output  1  PC takes branch target.
REQ-018 ERROR  output  1  memory-wait timeout; sticky until RST.
REQ-019 STALL_CYCLES  output  32  count of cycles with STALL_IF=1.

Function
REQ-020 FSM states RUN, MEM_WAIT, MDU_WAIT, ERROR; state, wait counter (8 bit), STALL_CYCLES registered; all other outputs combinational from state and inputs.
REQ-021 RUN evaluation, strict priority, first match wins:
- (a) MEM_REQ_MEM & !DCACHE_READY: STALL_IF/ID/EX/MEM=1, PC_WRITE_EN=0; next MEM_WAIT, wait counter<=1.
- (b) MDU_START_EX & !MDU_DONE: STALL_IF/ID/EX=1, FLUSH_MEM=1, PC_WRITE_EN=0; next MDU_WAIT.
- (c) BRANCH_TAKEN_EX: FLUSH_ID=1, FLUSH_EX=1, PC_REDIRECT=1, PC_WRITE_EN=1; stay RUN.
- (d) load-use: MEM_READ_EX & RD_EX!=0 & ((RS1_USED_ID & RS1_ID==RD_EX) | (RS2_USED_ID & RS2_ID==RD_EX)): STALL_IF/ID=1, FLUSH_EX=1, PC_WRITE_EN=0; stay RUN.
- (e) otherwise: all stall/flush/redirect 0, PC_WRITE_EN=1.
REQ-022 Unlisted outputs in each case are 0.
REQ-023 MEM_WAIT, DCACHE_READY=0: STALL_IF/ID/EX/MEM=1, PC_WRITE_EN=0, wait counter +1; counter==MEM_TIMEOUT -> ERROR.
REQ-024 MEM_WAIT, DCACHE_READY=1 (exit cycle): outputs and next state per RUN rules (b)-(e); branch or load-use in held EX acts this cycle.
REQ-025 MDU_WAIT, MDU_DONE=0: STALL_IF/ID/EX=1, FLUSH_MEM=1, PC_WRITE_EN=0.
REQ-026 MDU_WAIT, MDU_DONE=1: all stall/flush 0, PC_WRITE_EN=1; next RUN.
REQ-027 ERROR: STALL_IF/ID/EX/MEM=1, PC_WRITE_EN=0, ERROR=1; leaves only on RST.
REQ-028 Taken branch during MEM_WAIT/MDU_WAIT: no redirect; EX held, branch resolves on exit cycle.
REQ-029 STALL_CYCLES increments by 1 each cycle STALL_IF=1, incl. ERROR; wraps 0xFFFFFFFF -> 0.
REQ-030 RD_EX==0 never causes load-use stall.

Reset
REQ-031 RST=1 at rising edge: state<=RUN, wait counter<=0, STALL_CYCLES<=0, ERROR<=0; overrides any state, including mid-MEM_WAIT/MDU_WAIT/ERROR.
REQ-032 While RST=1: all stall/flush/redirect outputs 0, PC_WRITE_EN=1.

Structure
REQ-033 State encodings (2 bit) and MEM_TIMEOUT default live in shared pipeline definitions file for pipeline and bench.
REQ-034 One sub-module: WAIT_TIMER (8-bit clear/increment counter, terminal-count flag vs MEM_TIMEOUT).

Verification
REQ-035 Load x5 in EX, ID reads x5 via RS2 -> 1 cycle STALL_IF/ID=1, FLUSH_EX=1, PC_WRITE_EN=0; STALL_CYCLES=1.
REQ-036 MEM_REQ_MEM=1, DCACHE_READY low 3 cycles then high -> 3 cycles all four stalls, 4th cycle all 0; STALL_CYCLES=3.
REQ-037 MEM_TIMEOUT=4, DCACHE_READY never high -> ERROR=1 on 5th cycle after entry, held; RST -> ERROR=0, state RUN.
REQ-038 MDU_START_EX, MDU_DONE after 6 cycles -> 6 cycles STALL_IF/ID/EX=1 and FLUSH_MEM=1, 7th cycle all 0.
REQ-039 BRANCH_TAKEN_EX with MEM stall pending -> no redirect while waiting; on DCACHE_READY cycle FLUSH_ID=FLUSH_EX=PC_REDIRECT=1.
REQ-040 STALL_CYCLES preloaded to 0xFFFFFFFF via forced stall -> one more stall cycle reads 0.
